// File: rtl/fsqrt_issue.sv
// fsqrt_issue: issue and writeback buffer for a fixed-latency square-root datapath.
//
// Accepts single-precision operands with a destination tag and forwards each
// operand straight to the datapath (sq_x). Special operands (zero, denormal,
// negative, NaN, +inf) are classified at acceptance and their result is
// substituted at writeback. Each result is placed in a small FIFO and handed
// to writeback in acceptance order. Requests are only accepted while total
// occupancy (in flight plus buffered) is below DEPTH, so the FIFO cannot
// overflow.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   in_valid/in_ready    request handshake; in_x operand, in_tag destination tag
//   sq_x                 operand to the datapath (combinational copy of in_x)
//   sq_y                 datapath result, valid LAT edges after sq_x
//   out_valid/out_ready  result handshake; out_y, out_tag, out_invalid
//   busy                 at least one request in flight or buffered
module fsqrt_issue #(
   parameter int TAG_W = 5,
   parameter int DEPTH = 4,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      sq_x,
   input  logic [31:0]      sq_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_invalid,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Returns {override_en, invalid, override_value}.
   function automatic logic [33:0] classify(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] m;
      logic [33:0] r;
      e = x[30:23];
      m = x[22:0];
      r = '0;
      if (e == 8'h00)
         r = {1'b1, 1'b0, x[31], 31'b0};
      else if (x[31])
         r = {1'b1, 1'b1, 32'h7FC00000};
      else if (e == 8'hFF && m != 23'd0)
         r = {1'b1, 1'b0, 32'h7FC00000};
      else if (e == 8'hFF)
         r = {1'b1, 1'b0, 32'h7F800000};
      return r;
   endfunction

   logic              accept, push, pop, fifo_nonempty;
   logic [CW-1:0]     occ, fcnt;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [33:0]       cls;

   logic [LAT:1]      vld_p;
   logic [TAG_W-1:0]  tag_p     [1:LAT];
   logic              ovr_en_p  [1:LAT];
   logic              inv_p     [1:LAT];
   logic [31:0]       ovr_val_p [1:LAT];

   logic [31:0]       mem_y   [DEPTH];
   logic [TAG_W-1:0]  mem_tag [DEPTH];
   logic              mem_inv [DEPTH];

   assign sq_x          = in_x;
   assign in_ready      = rstn && (occ < CW'(DEPTH));
   assign accept        = in_valid && in_ready;
   assign fifo_nonempty = (fcnt != '0);
   assign pop           = fifo_nonempty && out_ready;
   assign push          = vld_p[LAT];
   assign busy          = (occ != '0);
   assign cls           = classify(in_x);

   // Stage 1: capture tag and classification on the accepting edge.
   always_ff @(posedge clk) begin
      if (!rstn) vld_p[1] <= 1'b0;
      else       vld_p[1] <= accept;
      tag_p[1]     <= in_tag;
      ovr_en_p[1]  <= cls[33];
      inv_p[1]     <= cls[32];
      ovr_val_p[1] <= cls[31:0];
   end

   // Stages 2..LAT: plain shift, tracking the datapath latency.
   for (genvar g = 2; g <= LAT; g++) begin : g_stage
      always_ff @(posedge clk) begin
         if (!rstn) vld_p[g] <= 1'b0;
         else       vld_p[g] <= vld_p[g-1];
         tag_p[g]     <= tag_p[g-1];
         ovr_en_p[g]  <= ovr_en_p[g-1];
         inv_p[g]     <= inv_p[g-1];
         ovr_val_p[g] <= ovr_val_p[g-1];
      end
   end

   // Stage LAT -> FIFO: sq_y lines up with the entry leaving the last stage.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_y[wr_ptr]   <= ovr_en_p[LAT] ? ovr_val_p[LAT] : sq_y;
         mem_tag[wr_ptr] <= tag_p[LAT];
         mem_inv[wr_ptr] <= inv_p[LAT];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         fcnt   <= fcnt + CW'(push) - CW'(pop);
         occ    <= occ + CW'(accept) - CW'(pop);
      end
   end

   // FIFO storage is not reset; outputs are forced to zero while empty so the
   // reset-visible values are defined without clearing the data array.
   assign out_valid   = fifo_nonempty;
   assign out_y       = fifo_nonempty ? mem_y[rd_ptr]   : '0;
   assign out_tag     = fifo_nonempty ? mem_tag[rd_ptr] : '0;
   assign out_invalid = fifo_nonempty ? mem_inv[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fsqrt_issue.sv
module tb_fsqrt_issue;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic [4:0]  in_tag = '0;
   logic [31:0] sq_x;
   logic [31:0] sq_y = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_y;
   logic [4:0]  out_tag;
   logic        out_invalid;
   logic        busy;

   int total = 0;
   int bad = 0;
   logic [4:0]  got_tag[$];
   logic [31:0] got_y[$];

   fsqrt_issue #(.TAG_W(5), .DEPTH(4), .LAT(1)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_tag(in_tag), .sq_x(sq_x), .sq_y(sq_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_tag(out_tag), .out_invalid(out_invalid), .busy(busy)
   );

   always #5 clk = ~clk;

   // One-cycle square-root datapath model for the operands used here.
   function automatic logic [31:0] sqrt_model(input logic [31:0] x);
      case (x)
         32'h3F800000: return 32'h3F800000;
         32'h40800000: return 32'h40000000;
         32'h41100000: return 32'h40400000;
         32'h41800000: return 32'h40800000;
         default:      return 32'hDEADBEEF;
      endcase
   endfunction

   always @(posedge clk) sq_y <= sqrt_model(sq_x);

   // Record any pop happening on the coming edge, then advance one cycle.
   task automatic step_mon();
      if (out_valid && out_ready) begin
         got_tag.push_back(out_tag);
         got_y.push_back(out_y);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step_mon();
      step_mon();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      total++; if (out_y !== 32'h0 || out_tag !== 5'd0 || out_invalid !== 1'b0) begin
         bad++; $display("FAIL rst_outputs got y=%h tag=%0d inv=%0b exp 0/0/0", out_y, out_tag, out_invalid);
      end
      rstn = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b exp=1", in_ready); end
      step_mon();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      in_valid = 1'b1; in_x = 32'h40800000; in_tag = 5'd3;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b exp=1", in_ready); end
      step_mon();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", busy); end
      step_mon();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
      total++; if (out_y !== 32'h40000000) begin bad++; $display("FAIL basic_y got=%h exp=40000000", out_y); end
      total++; if (out_tag !== 5'd3 || out_invalid !== 1'b0) begin
         bad++; $display("FAIL basic_tag_inv got=%0d/%0b exp=3/0", out_tag, out_invalid);
      end
      step_mon();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_drained got valid=%0b busy=%0b exp 0/0", out_valid, busy);
      end
   endtask

   task automatic test_special();
      logic [31:0] xs  [7] = '{32'hC0800000, 32'h80000000, 32'h7F800000, 32'h7FC00001,
                               32'h00000001, 32'hFF800000, 32'h41100000};
      logic [31:0] ys  [7] = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                               32'h00000000, 32'h7FC00000, 32'h40400000};
      logic        inv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_x = xs[i]; in_tag = 5'(i + 8);
         step_mon();
         in_valid = 1'b0;
         step_mon();
         total++;
         if (out_valid !== 1'b1 || out_y !== ys[i] || out_invalid !== inv[i] || out_tag !== 5'(i + 8)) begin
            bad++;
            $display("FAIL special_%0d got v=%0b y=%h inv=%0b tag=%0d exp v=1 y=%h inv=%0b tag=%0d",
                     i, out_valid, out_y, out_invalid, out_tag, ys[i], inv[i], i + 8);
         end
      end
      step_mon();
   endtask

   task automatic test_backpressure();
      logic [31:0] xs [6] = '{32'h40800000, 32'h41100000, 32'h41800000,
                              32'h3F800000, 32'h40800000, 32'h41100000};
      logic [31:0] ys [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                              32'h3F800000, 32'h40000000, 32'h40400000};
      int idx;
      logic acc;
      got_tag.delete(); got_y.delete();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_x = xs[k]; in_tag = 5'(k);
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_%0d got=%0b exp=1", k, in_ready); end
         step_mon();
      end
      in_x = xs[4]; in_tag = 5'd4;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
      step_mon();
      step_mon();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_ready got=%0b exp=0", in_ready); end
      total++; if (out_valid !== 1'b1 || out_tag !== 5'd0 || out_y !== 32'h40000000) begin
         bad++; $display("FAIL bp_head_stable got v=%0b tag=%0d y=%h exp 1/0/40000000", out_valid, out_tag, out_y);
      end
      out_ready = 1'b1;
      idx = 4;
      for (int c = 0; c < 30 && !(idx == 6 && got_tag.size() == 6); c++) begin
         if (idx < 6) begin
            in_valid = 1'b1; in_x = xs[idx]; in_tag = 5'(idx);
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && in_ready;
         step_mon();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      total++; if (got_tag.size() != 6 || idx != 6) begin
         bad++; $display("FAIL bp_count got pops=%0d accepts=%0d exp 6/6", got_tag.size(), idx);
      end
      for (int i = 0; i < 6 && i < got_tag.size(); i++) begin
         total++;
         if (got_tag[i] !== 5'(i) || got_y[i] !== ys[i]) begin
            bad++; $display("FAIL bp_order_%0d got tag=%0d y=%h exp tag=%0d y=%h", i, got_tag[i], got_y[i], i, ys[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xs [8] = '{32'h3F800000, 32'h41100000, 32'h40800000, 32'h41800000,
                              32'h3F800000, 32'h41100000, 32'h40800000, 32'h41800000};
      logic [31:0] ys [8] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000,
                              32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000};
      got_tag.delete(); got_y.delete();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_x = xs[k]; in_tag = 5'(10 + k);
         step_mon();
      end
      in_valid = 1'b0;
      step_mon();
      step_mon();
      out_ready = 1'b1;
      for (int k = 2; k < 8; k++) begin
         in_valid = 1'b1; in_x = xs[k]; in_tag = 5'(10 + k);
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_steady_%0d got ready=%0b valid=%0b busy=%0b exp 1/1/1", k, in_ready, out_valid, busy);
         end
         step_mon();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 10 && got_tag.size() < 8; c++) step_mon();
      total++; if (got_tag.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got_tag.size()); end
      for (int i = 0; i < 8 && i < got_tag.size(); i++) begin
         total++;
         if (got_tag[i] !== 5'(10 + i) || got_y[i] !== ys[i]) begin
            bad++; $display("FAIL b2b_order_%0d got tag=%0d y=%h exp tag=%0d y=%h", i, got_tag[i], got_y[i], 10 + i, ys[i]);
         end
      end
      step_mon();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_reset_midflight();
      int waited;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_x = 32'h40800000; in_tag = 5'(20 + k);
         step_mon();
      end
      in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", in_ready); end
      step_mon();
      rstn = 1'b1;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_rst_clear got valid=%0b busy=%0b exp 0/0", out_valid, busy);
      end
      out_ready = 1'b1;
      step_mon();
      step_mon();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_stale got valid=%0b busy=%0b tag=%0d exp 0/0", out_valid, busy, out_tag);
      end
      in_valid = 1'b1; in_x = 32'h41800000; in_tag = 5'd7;
      step_mon();
      in_valid = 1'b0;
      waited = 0;
      while (out_valid !== 1'b1 && waited < 10) begin
         step_mon();
         waited++;
      end
      total++;
      if (out_valid !== 1'b1 || waited != 1 || out_y !== 32'h40800000 || out_tag !== 5'd7 || out_invalid !== 1'b0) begin
         bad++; $display("FAIL mid_new_req got v=%0b wait=%0d y=%h tag=%0d exp v=1 wait=1 y=40800000 tag=7",
                         out_valid, waited, out_y, out_tag);
      end
      step_mon();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_special();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
